// File: rtl/atmega_spi_s_if.sv
// Register-bus bundle between the CPU side and the ATmega-style SPI slave.
// Signal suffixes are seen from the peripheral: _i is driven by the CPU side.
interface atmega_spi_s_if #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 8
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr_i;
  logic                         wr_i;
  logic                         rd_i;
  logic [7:0]                   bus_i;
  logic [7:0]                   bus_o;
  logic                         int_o;
  logic                         int_ack_i;

  modport master (
    output addr_i, wr_i, rd_i, bus_i, int_ack_i,
    input  bus_o, int_o
  );

  modport slave (
    input  addr_i, wr_i, rd_i, bus_i, int_ack_i,
    output bus_o, int_o
  );
endinterface

// File: rtl/atmega_spi_s.sv
// ATmega-style SPI slave with SPCR/SPSR/SPDR on the 8-bit register bus.
// Define ATMEGA_SPI_S_OVR_EN to enable the SPSR.OVR overrun flag and drop-on-overrun.
module atmega_spi_s #(
  parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 'h22,
  parameter int unsigned                  SYNC_STAGES       = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  atmega_spi_s_if.slave bus,
  output logic          io_connect_o,
  input  logic          sck_i,
  input  logic          ss_ni,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o
);

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev, ss_prev;
  logic [7:0]             spcr, tx_buf, rx_buf, shreg, rx_sh;
  logic [2:0]             bit_cnt;
  logic                   spif, wcol, ovr, clr_armed;

  logic spie, spe, dord, mstr, cpol, cpha;
  logic sck_s, ss_s, mosi_s;
  logic active, busy, ss_fall, sck_rise, sck_fall, lead_ev, trail_ev;
  logic sample_ev, shift_ev, byte_done;
  logic [7:0] rx_next;
  logic sel_spcr, sel_spsr, sel_spdr, spdr_wr, spdr_acc, spsr_rd, clr_req;
  logic ovr_bit;

  assign spie = spcr[7];
  assign spe  = spcr[6];
  assign dord = spcr[5];
  assign mstr = spcr[4];
  assign cpol = spcr[3];
  assign cpha = spcr[2];

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign active   = spe & ~mstr & ~ss_s;
  assign busy     = active & (bit_cnt != '0);
  assign ss_fall  = ss_prev & ~ss_s;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign lead_ev  = cpol ? sck_fall : sck_rise;
  assign trail_ev = cpol ? sck_rise : sck_fall;

  // The first shift edge of each byte is suppressed (bit_cnt==0): in CPHA=1 it
  // would skip the preloaded MSB/LSB, in CPHA=0 it would clobber the reload.
  assign sample_ev = active & (cpha ? trail_ev : lead_ev);
  assign shift_ev  = active & (cpha ? lead_ev : trail_ev) & (bit_cnt != '0);
  assign byte_done = sample_ev & (bit_cnt == 3'd7);
  assign rx_next   = dord ? {mosi_s, rx_sh[7:1]} : {rx_sh[6:0], mosi_s};

  assign sel_spcr = (bus.addr_i == SPCR_ADDR);
  assign sel_spsr = (bus.addr_i == SPSR_ADDR);
  assign sel_spdr = (bus.addr_i == SPDR_ADDR);
  assign spdr_wr  = bus.wr_i & sel_spdr;
  assign spdr_acc = (bus.wr_i | bus.rd_i) & sel_spdr;
  assign spsr_rd  = bus.rd_i & sel_spsr;
  assign clr_req  = clr_armed & spdr_acc;

`ifdef ATMEGA_SPI_S_OVR_EN
  assign ovr_bit = ovr;
`else
  assign ovr_bit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sync  <= '1;
      ss_sync   <= '1;
      mosi_sync <= '1;
      sck_prev  <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else if (!active) begin
      bit_cnt <= '0;
    end else if (ss_fall) begin
      shreg   <= tx_buf;
      bit_cnt <= '0;
    end else begin
      if (sample_ev) begin
        rx_sh   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) shreg <= tx_buf;
      end
      if (shift_ev) shreg <= dord ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      spcr      <= '0;
      tx_buf    <= '0;
      rx_buf    <= '0;
      spif      <= 1'b0;
      wcol      <= 1'b0;
      ovr       <= 1'b0;
      clr_armed <= 1'b0;
    end else begin
      if (bus.wr_i && sel_spcr) spcr <= bus.bus_i;
      if (spdr_wr && !busy) tx_buf <= bus.bus_i;

`ifdef ATMEGA_SPI_S_OVR_EN
      if (byte_done && !spif) rx_buf <= rx_next;
      if (byte_done && spif) ovr <= 1'b1;
      else if (clr_req)      ovr <= 1'b0;
`else
      if (byte_done) rx_buf <= rx_next;
      ovr <= 1'b0;
`endif

      if (byte_done)                      spif <= 1'b1;
      else if (bus.int_ack_i || clr_req)  spif <= 1'b0;

      if (spdr_wr && busy) wcol <= 1'b1;
      else if (clr_req)    wcol <= 1'b0;

      if (spsr_rd && spif) clr_armed <= 1'b1;
      else if (spdr_acc)   clr_armed <= 1'b0;
    end
  end

  always_comb begin
    bus.bus_o = '0;
    if (bus.rd_i) begin
      if (sel_spcr)      bus.bus_o = spcr;
      else if (sel_spsr) bus.bus_o = {spif, wcol, ovr_bit, 5'b00000};
      else if (sel_spdr) bus.bus_o = rx_buf;
    end
  end

  assign bus.int_o    = spif & spie;
  assign io_connect_o = spe & ~mstr;
  assign miso_oe_o    = active;
  assign miso_o       = active ? (dord ? shreg[0] : shreg[7]) : 1'b1;

endmodule

// File: tb/tb_atmega_spi_s.sv
// Bench for atmega_spi_s: bus-driven register access plus a behavioural SPI master.
// Honours ATMEGA_SPI_S_OVR_EN for the overrun expectations.
module tb_atmega_spi_s;
  localparam logic [7:0] SPCR = 8'h20;
  localparam logic [7:0] SPSR = 8'h21;
  localparam logic [7:0] SPDR = 8'h22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, io_connect;
  logic cpol_m = 1'b0, cpha_m = 1'b0, dord_m = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  always #5 clk = ~clk;

  atmega_spi_s_if #(.BUS_ADDR_DATA_LEN(8)) bus ();

  atmega_spi_s #(
    .BUS_ADDR_DATA_LEN(8),
    .SPCR_ADDR(SPCR),
    .SPSR_ADDR(SPSR),
    .SPDR_ADDR(SPDR),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus),
    .io_connect_o(io_connect),
    .sck_i(sck),
    .ss_ni(ss_n),
    .mosi_i(mosi),
    .miso_o(miso),
    .miso_oe_o(miso_oe)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.bus_i = d; bus.wr_i = 1'b1;
    @(negedge clk);
    bus.wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.rd_i = 1'b1;
    #2 d = bus.bus_o;
    @(negedge clk);
    bus.rd_i = 1'b0;
  endtask

  // Master sends bits [first, first+n) of tx; sck half period is 4 clk (clk/8).
  task automatic spi_bits(input logic [7:0] tx, input int first, input int n,
                          input logic [7:0] rx_in, output logic [7:0] rx_out);
    logic [7:0] r;
    int b;
    r = rx_in;
    for (int i = first; i < first + n; i++) begin
      b = dord_m ? i : 7 - i;
      if (!cpha_m) begin
        mosi = tx[b];
        repeat (4) @(negedge clk);
        r[b] = miso; sck = ~cpol_m;
        repeat (4) @(negedge clk);
        sck = cpol_m;
      end else begin
        repeat (4) @(negedge clk);
        sck = ~cpol_m; mosi = tx[b];
        repeat (4) @(negedge clk);
        r[b] = miso; sck = cpol_m;
      end
    end
    rx_out = r;
  endtask

  task automatic ss_low();
    @(negedge clk); ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (6) @(negedge clk); ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic ord, input logic ie);
    cpol_m = pol; cpha_m = pha; dord_m = ord;
    @(negedge clk); sck = pol;
    repeat (4) @(negedge clk);
    reg_write(SPCR, {ie, 1'b1, ord, 1'b0, pol, pha, 2'b00});
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    vectors++; if (miso !== 1'b1) begin miscompares++; $display("FAIL rst_miso: got %b want 1", miso); end
    vectors++; if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL rst_miso_oe: got %b want 0", miso_oe); end
    vectors++; if (bus.int_o !== 1'b0) begin miscompares++; $display("FAIL rst_int: got %b want 0", bus.int_o); end
    vectors++; if (io_connect !== 1'b0) begin miscompares++; $display("FAIL rst_io_connect: got %b want 0", io_connect); end
    @(negedge clk); rst_n = 1'b1;
    reg_read(SPCR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rst_spcr: got %02h want 00", d); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rst_spsr: got %02h want 00", d); end
    reg_read(SPDR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rst_spdr: got %02h want 00", d); end
  endtask

  task automatic test_mode0();
    logic [7:0] d, r, e;
    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (io_connect !== 1'b1) begin miscompares++; $display("FAIL m0_io_connect: got %b want 1", io_connect); end
    reg_write(SPDR, 8'hA5); exp_miso_q.push_back(8'hA5);
    ss_low();
    vectors++; if (miso_oe !== 1'b1) begin miscompares++; $display("FAIL m0_miso_oe: got %b want 1", miso_oe); end
    exp_rx_q.push_back(8'h3C);
    spi_bits(8'h3C, 0, 8, 8'h00, r);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL m0_master_rx: got %02h want %02h", r, e); end
    vectors++; if (bus.int_o !== 1'b1) begin miscompares++; $display("FAIL m0_int_set: got %b want 1", bus.int_o); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL m0_spsr_spif: got %02h want 80", d); end
    @(negedge clk); bus.int_ack_i = 1'b1;
    @(negedge clk); bus.int_ack_i = 1'b0;
    vectors++; if (bus.int_o !== 1'b0) begin miscompares++; $display("FAIL m0_int_ack: got %b want 0", bus.int_o); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL m0_spsr_acked: got %02h want 00", d); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL m0_spdr: got %02h want %02h", d, e); end
    ss_high();
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] d, r, e;
    set_mode(1'b1, 1'b1, 1'b1, 1'b0);
    reg_read(SPCR, d);
    vectors++; if (d !== 8'h6C) begin miscompares++; $display("FAIL m3_spcr: got %02h want 6c", d); end
    reg_write(SPDR, 8'h01); exp_miso_q.push_back(8'h01);
    ss_low();
    exp_rx_q.push_back(8'h80);
    spi_bits(8'h80, 0, 8, 8'h00, r);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL m3_master_rx: got %02h want %02h", r, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL m3_spsr: got %02h want 80", d); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL m3_spdr: got %02h want %02h", d, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL m3_spsr_clr: got %02h want 00", d); end
    ss_high();
  endtask

  task automatic test_wcol();
    logic [7:0] d, r, e;
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(SPDR, 8'h3A); exp_miso_q.push_back(8'h3A);
    ss_low();
    exp_rx_q.push_back(8'hF0);
    spi_bits(8'hF0, 0, 3, 8'h00, r);
    reg_write(SPDR, 8'h55);
    spi_bits(8'hF0, 3, 5, r, r);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL wcol_old_tx: got %02h want %02h", r, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'hC0) begin miscompares++; $display("FAIL wcol_spsr: got %02h want c0", d); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL wcol_spdr: got %02h want %02h", d, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL wcol_clr: got %02h want 00", d); end
    reg_write(SPDR, 8'h55);
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL wcol_idle_wr: got %02h want 00", d); end
    ss_high();
  endtask

  task automatic test_abort();
    logic [7:0] d, r, e;
    ss_low();
    exp_rx_q.push_back(8'hF0);
    spi_bits(8'h0F, 0, 5, 8'h00, r);
    ss_high();
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL abort_no_spif: got %02h want 00", d); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL abort_rx_kept: got %02h want %02h", d, e); end
    exp_miso_q.push_back(8'h55);
    ss_low();
    exp_rx_q.push_back(8'h99);
    spi_bits(8'h99, 0, 8, 8'h00, r);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL abort_tx_kept: got %02h want %02h", r, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL abort_full_spif: got %02h want 80", d); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL abort_full_rx: got %02h want %02h", d, e); end
    ss_high();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, r1, r2, e, exp_spsr;
    reg_write(SPDR, 8'h77);
    exp_miso_q.push_back(8'h77); exp_miso_q.push_back(8'h77);
`ifdef ATMEGA_SPI_S_OVR_EN
    exp_rx_q.push_back(8'h11); exp_spsr = 8'hA0;
`else
    exp_rx_q.push_back(8'h22); exp_spsr = 8'h80;
`endif
    ss_low();
    spi_bits(8'h11, 0, 8, 8'h00, r1);
    spi_bits(8'h22, 0, 8, 8'h00, r2);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r1 !== e) begin miscompares++; $display("FAIL b2b_tx0: got %02h want %02h", r1, e); end
    e = exp_miso_q.pop_front();
    vectors++; if (r2 !== e) begin miscompares++; $display("FAIL b2b_tx1: got %02h want %02h", r2, e); end
    ss_high();
    reg_read(SPSR, d);
    vectors++; if (d !== exp_spsr) begin miscompares++; $display("FAIL b2b_spsr: got %02h want %02h", d, exp_spsr); end
    reg_read(SPDR, d); e = exp_rx_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL b2b_rx: got %02h want %02h", d, e); end
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL b2b_clr: got %02h want 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, r, e;
    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    reg_write(SPDR, 8'h00); exp_miso_q.push_back(8'h00);
    ss_low();
    spi_bits(8'h42, 0, 8, 8'h00, r);
    repeat (4) @(negedge clk);
    e = exp_miso_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL rm_tx: got %02h want %02h", r, e); end
    spi_bits(8'hC3, 0, 4, 8'h00, r);
    vectors++; if (bus.int_o !== 1'b1) begin miscompares++; $display("FAIL rm_int_before: got %b want 1", bus.int_o); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL rm_miso_before: got %b want 0", miso); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    vectors++; if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL rm_miso_oe: got %b want 0", miso_oe); end
    vectors++; if (miso !== 1'b1) begin miscompares++; $display("FAIL rm_miso: got %b want 1", miso); end
    vectors++; if (bus.int_o !== 1'b0) begin miscompares++; $display("FAIL rm_int: got %b want 0", bus.int_o); end
    vectors++; if (io_connect !== 1'b0) begin miscompares++; $display("FAIL rm_io_connect: got %b want 0", io_connect); end
    repeat (3) @(negedge clk); rst_n = 1'b1;
    spi_bits(8'hC3, 4, 4, r, r);
    ss_high();
    reg_read(SPSR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rm_spsr: got %02h want 00", d); end
    reg_read(SPCR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rm_spcr: got %02h want 00", d); end
    reg_read(SPDR, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rm_spdr: got %02h want 00", d); end
  endtask

  initial begin
    bus.addr_i = '0; bus.wr_i = 1'b0; bus.rd_i = 1'b0;
    bus.bus_i = '0; bus.int_ack_i = 1'b0;
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_wcol();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/atmega_spi_s.md
Name: atmega_spi_s

Overview:
- ATmega-style SPI slave (peripheral end) on the same 8-bit register bus as the SPI master peripheral: SPCR/SPSR/SPDR register map.
- Samples an external sck_i/ss_ni/mosi_i, drives miso_o, and raises SPIF/int_o per received byte.
- Sits in the IO block next to the master; the pin mux selects it through io_connect_o.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of addr_i
- SPCR_ADDR, 'h20, control register address
- SPSR_ADDR, 'h21, status register address
- SPDR_ADDR, 'h22, data register address
- SYNC_STAGES, 2, synchronizer flops on sck_i/ss_ni/mosi_i (min 2)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- addr_i  in  BUS_ADDR_DATA_LEN  register address
- wr_i  in  1  register write strobe
- rd_i  in  1  register read strobe
- bus_i  in  8  write data
- bus_o  out  8  read data, combinational; 0 when rd_i=0 or address miss
- int_o  out  1  SPIF & SPIE
- int_ack_i  in  1  interrupt acknowledge, clears SPIF
- io_connect_o  out  1  = SPE & ~MSTR
- sck_i  in  1  external SPI clock (async)
- ss_ni  in  1  slave select, active-low (async)
- mosi_i  in  1  serial data in (async)
- miso_o  out  1  serial data out
- miso_oe_o  out  1  MISO output enable

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: all registers, tx_buf and rx_buf = 0; shift reg = 0; bit_cnt = 0; synchronizers = 1 (idle).
  - Output values in reset: int_o=0, io_connect_o=0, miso_o=1, miso_oe_o=0.
- SPCR (R/W, all bits stored):
  - b7 SPIE; b6 SPE; b5 DORD (1=LSB first); b4 MSTR (must be 0; if 1, the block ignores the pins); b3 CPOL; b2 CPHA.
- SPSR:
  - b7 SPIF (RO); b6 WCOL (RO); b5 OVR (optional feature, else reads 0); others read 0.
  - Writes to SPSR are ignored.
- SPDR:
  - Write loads tx_buf.
  - Read returns rx_buf.
- Input synchronization: SYNC_STAGES flops, plus one history flop for edge detection.
  - Pin-to-internal-event latency: SYNC_STAGES+1 clk.
  - Supported sck_i frequency: up to clk_i/4.
- Enable: active = SPE & ~MSTR & ~ss_sync. When inactive:
  - no shifting;
  - bit_cnt held at 0;
  - miso_oe_o=0, miso_o=1.
- Edge classification:
  - leading = sck edge away from CPOL level; trailing = edge back to CPOL level.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- Shift register load:
  - loaded from tx_buf on the synced ss falling edge while enabled;
  - reloaded from tx_buf after every completed byte (back-to-back bytes without SS toggle).
  - CPHA=0: the first bit is therefore valid before the first leading edge.
- miso_o = DORD ? shreg[0] : shreg[7], while active.
- Sample and completion:
  - Each sample edge shifts in the synced mosi (MSB-first into bit0 side, LSB-first into bit7 side) and increments bit_cnt.
  - 8th sample: rx_buf <= assembled byte and SPIF <= 1 in the same clk; bit_cnt <= 0.
- busy = active & (bit_cnt != 0).
  - SPDR write while busy: WCOL <= 1, tx_buf unchanged.
  - SPDR write otherwise: accepted.
- SPIF/WCOL clear:
  - A read of SPSR with SPIF=1 arms the clear.
  - A following SPDR read or write clears SPIF and WCOL and disarms.
  - int_ack_i clears SPIF immediately.
- Simultaneous set and clear of SPIF in the same clk: set wins.
- SS deasserted mid-byte:
  - bit_cnt <= 0; partial byte discarded;
  - no SPIF; rx_buf unchanged; tx_buf retained for the next select.
- SPE cleared mid-byte: same as the SS abort; registers keep their values.
- Async reset mid-transfer: immediate return to the reset state; no SPIF.

Optional Feature:
- Macro: ATMEGA_SPI_S_OVR_EN.
- Defined:
  - SPSR b5 OVR is set when a byte completes while SPIF is still 1.
  - In that case rx_buf is NOT overwritten; the new byte is dropped.
  - OVR clears with SPIF via the SPSR-read-then-SPDR-access sequence only; int_ack_i does not clear it.
- Undefined:
  - SPSR b5 reads 0.
  - Each completed byte overwrites rx_buf unconditionally.

Test Plan:
- Mode 0, MSB-first, SPE=1 SPIE=1, tx_buf=0xA5; master sends 0x3C at clk/8 -> master receives 0xA5, rx_buf=0x3C, SPIF=1, int_o=1; int_ack_i -> SPIF=0.
- Mode 3 (CPOL=1 CPHA=1), DORD=1, tx_buf=0x01; master sends 0x80 -> master receives 0x01 LSB first, SPDR read=0x80.
- SPDR write of 0x55 after 3 bits of a byte -> WCOL=1, byte still shifts the old tx_buf; SPSR read then SPDR read -> SPIF=0, WCOL=0.
- ss_ni deasserted after 5 bits, then a full byte 0x99 -> no SPIF after the abort; rx_buf=0x99 after the full byte; bit alignment correct.
- Two back-to-back bytes 0x11, 0x22 without SS toggle, SPIF left uncleared -> rx_buf=0x22 (macro off); rx_buf=0x11 with OVR=1 (ATMEGA_SPI_S_OVR_EN on).
- rst_i low mid-byte -> all outputs at reset values within the same clk, miso_oe_o=0; no SPIF after release.
